// File: rtl/game_pkg.sv
// Shared definitions for the doodle game datapath: FSM state encoding,
// default playfield geometry and the platform table entry layout.
package game_pkg;

  // Collider scan FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default geometry, in pixels.
  localparam int DEF_NUM_BLOCKS   = 8;
  localparam int DEF_BLOCK_WIDTH  = 40;
  localparam int DEF_BLOCK_HEIGHT = 5;
  localparam int DEF_DOODLE_WIDTH = 20;

  // One platform table entry.
  typedef struct packed {
    logic        valid;
    logic [31:0] x;
    logic [31:0] y;
  } platform_t;

endpackage

// File: rtl/hit_test.sv
// Purely combinational overlap test between the doodle footprint and one
// platform. Every sum is widened to 33 bits so coordinates near 2^32 cannot
// wrap around and hide a real overlap.
import game_pkg::*;

module hit_test #(
  parameter int BLOCK_WIDTH  = DEF_BLOCK_WIDTH,
  parameter int BLOCK_HEIGHT = DEF_BLOCK_HEIGHT,
  parameter int DOODLE_WIDTH = DEF_DOODLE_WIDTH
) (
  input  platform_t   i_entry,
  input  logic        i_falling,
  input  logic [31:0] i_doodleX,
  input  logic [31:0] i_doodleY,
  output logic        o_hit
);

  logic [32:0] w_platBottom;
  logic [32:0] w_platRight;
  logic [32:0] w_doodleRight;
  logic        w_yInside;
  logic        w_xOverlap;

  assign w_platBottom  = {1'b0, i_entry.y} + 33'(BLOCK_HEIGHT);
  assign w_platRight   = {1'b0, i_entry.x} + 33'(BLOCK_WIDTH);
  assign w_doodleRight = {1'b0, i_doodleX} + 33'(DOODLE_WIDTH);

  // The doodle's feet must sit inside the platform slab vertically, and the
  // two horizontal spans must overlap by at least one pixel.
  always_comb begin
    w_yInside  = (i_entry.y <= i_doodleY) && ({1'b0, i_doodleY} < w_platBottom);
    w_xOverlap = (w_doodleRight > {1'b0, i_entry.x}) && ({1'b0, i_doodleX} < w_platRight);
    o_hit      = i_entry.valid && i_falling && w_yInside && w_xOverlap;
  end

endmodule

// File: rtl/platform_collider.sv
// Platform collider: on each physics tick, walks the platform table one entry
// per clock and reports whether the (snapshotted) doodle lands on any of them.
// Optional feature: define COLLIDE_HIT_INDEX_EN to add the hitIdx output
// reporting the lowest-numbered platform that was hit.
import game_pkg::*;

module platform_collider #(
  parameter int NUM_BLOCKS   = DEF_NUM_BLOCKS,
  parameter int BLOCK_WIDTH  = DEF_BLOCK_WIDTH,
  parameter int BLOCK_HEIGHT = DEF_BLOCK_HEIGHT,
  parameter int DOODLE_WIDTH = DEF_DOODLE_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          physicsUpdate,
  input  logic [31:0]                   doodleX,
  input  logic [31:0]                   doodleY,
  input  logic                          falling,
  input  logic                          wrEn,
  input  logic [$clog2(NUM_BLOCKS)-1:0] wrIdx,
  input  logic                          wrValid,
  input  logic [31:0]                   wrX,
  input  logic [31:0]                   wrY,
  output logic                          hasCollide,
  output logic                          busy,
  output logic                          overrun
`ifdef COLLIDE_HIT_INDEX_EN
  ,output logic [$clog2(NUM_BLOCKS)-1:0] hitIdx
`endif
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  // Platform table; only the valid bits need a defined reset value.
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [31:0]           r_x [NUM_BLOCKS];
  logic [31:0]           r_y [NUM_BLOCKS];

  // Tick detection: previous level plus a registered tick pulse.
  logic r_prevUpdate;
  logic r_tick;

  // Scan state.
  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_acc;
  logic [31:0]      r_snapX;
  logic [31:0]      r_snapY;
  logic             r_snapFalling;
  logic             r_hasCollide;
  logic             r_overrun;

  platform_t w_entry;
  logic      w_hit;

  // Valid bits live under reset so a freshly reset table never matches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (wrEn) begin
      r_valid[wrIdx] <= wrValid;
    end
  end

  // Coordinates are don't-care until their valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      r_x[wrIdx] <= wrX;
      r_y[wrIdx] <= wrY;
    end
  end

  // Rising-edge detector on the physics tick level, registered once so the
  // scan starts one clock after the edge is seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prevUpdate <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_prevUpdate <= physicsUpdate;
      r_tick       <= physicsUpdate & ~r_prevUpdate;
    end
  end

  // The entry under evaluation reads the table as it stands this cycle, so a
  // write landing on the same index at this edge is seen only afterwards.
  always_comb begin
    w_entry.valid = r_valid[r_idx];
    w_entry.x     = r_x[r_idx];
    w_entry.y     = r_y[r_idx];
  end

  hit_test #(
    .BLOCK_WIDTH  (BLOCK_WIDTH),
    .BLOCK_HEIGHT (BLOCK_HEIGHT),
    .DOODLE_WIDTH (DOODLE_WIDTH)
  ) u_hitTest (
    .i_entry   (w_entry),
    .i_falling (r_snapFalling),
    .i_doodleX (r_snapX),
    .i_doodleY (r_snapY),
    .o_hit     (w_hit)
  );

  // Scan FSM: snapshot the doodle, walk every entry, then publish the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_acc         <= 1'b0;
      r_snapX       <= '0;
      r_snapY       <= '0;
      r_snapFalling <= 1'b0;
      r_hasCollide  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_tick) begin
            r_state       <= ST_SCAN;
            r_idx         <= '0;
            r_acc         <= 1'b0;
            r_snapX       <= doodleX;
            r_snapY       <= doodleY;
            r_snapFalling <= falling;
          end
        end
        ST_SCAN: begin
          r_acc <= r_acc | w_hit;
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_hasCollide <= r_acc;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // A tick seen while a scan is still running is dropped and remembered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (r_tick && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

`ifdef COLLIDE_HIT_INDEX_EN
  logic [IDX_W-1:0] r_firstIdx;
  logic [IDX_W-1:0] r_hitIdx;

  // Remember the first index that hits; scanning ascends, so it is the lowest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_firstIdx <= '0;
      r_hitIdx   <= '0;
    end else begin
      if ((r_state == ST_IDLE) && r_tick) begin
        r_firstIdx <= '0;
      end else if ((r_state == ST_SCAN) && w_hit && !r_acc) begin
        r_firstIdx <= r_idx;
      end
      if (r_state == ST_DONE) begin
        r_hitIdx <= r_firstIdx;
      end
    end
  end

  assign hitIdx = r_hitIdx;
`endif

  assign hasCollide = r_hasCollide;
  assign busy       = (r_state != ST_IDLE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_platform_collider.sv
// Directed bench for platform_collider with the default geometry
// (8 entries, 40x5 platforms, 20-pixel doodle). Works with or without
// COLLIDE_HIT_INDEX_EN defined.
module tb_platform_collider;

  localparam int NB = 8;

  logic        clk;
  logic        reset_n;
  logic        physicsUpdate;
  logic [31:0] doodleX;
  logic [31:0] doodleY;
  logic        falling;
  logic        wrEn;
  logic [2:0]  wrIdx;
  logic        wrValid;
  logic [31:0] wrX;
  logic [31:0] wrY;
  logic        hasCollide;
  logic        busy;
  logic        overrun;
`ifdef COLLIDE_HIT_INDEX_EN
  logic [2:0]  hitIdx;
`endif

  int checkCount;
  int failCount;
  logic lastResult;

  platform_collider #(.NUM_BLOCKS(NB)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .physicsUpdate (physicsUpdate),
    .doodleX       (doodleX),
    .doodleY       (doodleY),
    .falling       (falling),
    .wrEn          (wrEn),
    .wrIdx         (wrIdx),
    .wrValid       (wrValid),
    .wrX           (wrX),
    .wrY           (wrY),
    .hasCollide    (hasCollide),
    .busy          (busy),
    .overrun       (overrun)
`ifdef COLLIDE_HIT_INDEX_EN
    ,.hitIdx       (hitIdx)
`endif
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic f);
    @(negedge clk);
    doodleX = x;
    doodleY = y;
    falling = f;
  endtask

  task automatic writeEntry(input logic [2:0] idx, input logic v, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    wrEn    = 1'b1;
    wrIdx   = idx;
    wrValid = v;
    wrX     = x;
    wrY     = y;
    @(negedge clk);
    wrEn    = 1'b0;
  endtask

  // One full scan: the result must still be the old one 9 clocks after the
  // tick edge and the new one exactly 10 clocks after it.
  task automatic runScan(input string tag, input logic expected);
    @(negedge clk);
    physicsUpdate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    physicsUpdate = 1'b0;
    @(posedge clk);
    #1 checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    repeat (8) @(posedge clk);
    #1 checkOutput({tag, "_early"}, 32'(hasCollide), 32'(lastResult));
    @(posedge clk);
    #1 checkOutput(tag, 32'(hasCollide), 32'(expected));
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    lastResult = expected;
  endtask

  initial begin
    checkCount    = 0;
    failCount     = 0;
    lastResult    = 1'b0;
    reset_n       = 1'b0;
    physicsUpdate = 1'b0;
    doodleX       = '0;
    doodleY       = '0;
    falling       = 1'b0;
    wrEn          = 1'b0;
    wrIdx         = '0;
    wrValid       = 1'b0;
    wrX           = '0;
    wrY           = '0;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_hasCollide", 32'(hasCollide), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);

    // Basic hit on entry 3 and its falling=0 counterpart.
    writeEntry(3'd3, 1'b1, 32'd100, 32'd50);
    applyStimulus(32'd110, 32'd52, 1'b1);
    runScan("basic_hit", 1'b1);
    applyStimulus(32'd110, 32'd52, 1'b0);
    runScan("not_falling", 1'b0);

    // Boundary cases around the 100..139 x 50..54 platform.
    applyStimulus(32'd110, 32'd55, 1'b1);
    runScan("y_below", 1'b0);
    applyStimulus(32'd110, 32'd50, 1'b1);
    runScan("y_top", 1'b1);
    applyStimulus(32'd80, 32'd52, 1'b1);
    runScan("x_left_touch", 1'b0);
    applyStimulus(32'd139, 32'd52, 1'b1);
    runScan("x_right_in", 1'b1);
    applyStimulus(32'd140, 32'd52, 1'b1);
    runScan("x_right_out", 1'b0);

    // Coordinates near 2^32: sums must not wrap.
    writeEntry(3'd3, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFE);
    applyStimulus(32'hFFFF_FFE0, 32'hFFFF_FFFF, 1'b1);
    runScan("wrap", 1'b1);

    // Second tick 3 clocks into a scan is dropped and flags overrun.
    applyStimulus(32'hFFFF_FFE0, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    physicsUpdate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    physicsUpdate = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    physicsUpdate = 1'b1;
    @(posedge clk);
    #1 checkOutput("ovr_before", 32'(overrun), 32'd0);
    @(negedge clk);
    physicsUpdate = 1'b0;
    falling = 1'b1;
    @(posedge clk);
    #1 checkOutput("ovr_set", 32'(overrun), 32'd1);
    repeat (5) @(posedge clk);
    #1 checkOutput("ovr_early", 32'(hasCollide), 32'(lastResult));
    @(posedge clk);
    #1 checkOutput("ovr_result", 32'(hasCollide), 32'd0);
    checkOutput("ovr_idle", 32'(busy), 32'd0);
    lastResult = 1'b0;
    repeat (12) @(posedge clk);
    #1 checkOutput("ovr_no_rescan", 32'(hasCollide), 32'd0);
    checkOutput("ovr_sticky", 32'(overrun), 32'd1);

    // Write to entry 7 while index 2 is being evaluated: the new value counts.
    writeEntry(3'd3, 1'b0, 32'd100, 32'd50);
    applyStimulus(32'd110, 32'd52, 1'b1);
    @(negedge clk);
    physicsUpdate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    physicsUpdate = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    wrEn    = 1'b1;
    wrIdx   = 3'd7;
    wrValid = 1'b1;
    wrX     = 32'd100;
    wrY     = 32'd50;
    @(posedge clk);
    @(negedge clk);
    wrEn = 1'b0;
    repeat (5) @(posedge clk);
    #1 checkOutput("late_write_early", 32'(hasCollide), 32'd0);
    @(posedge clk);
    #1 checkOutput("late_write", 32'(hasCollide), 32'd1);
    lastResult = 1'b1;

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    physicsUpdate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    physicsUpdate = 1'b0;
    repeat (4) @(posedge clk);
    #1 checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1 checkOutput("arst_hasCollide", 32'(hasCollide), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 checkOutput("post_rst_hasCollide", 32'(hasCollide), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
